score_display_ctrl: RTL and testbench
=====================================

// Module: score_display_ctrl
// PURPOSE
//  Game-side controller for the 4-digit 7-seg score display. Holds both players'
//  scores, detects game over and decides what the display shows each cycle.
//  Rotates between "P1-x" and "P2-x" pages. On a win, blinks the winner's page.
//  Drives per-digit 3-bit codes into the existing digit mux/converter path.
// PARAMETERS
//  CLK_HZ     100_000_000  input clock frequency, Hz
//  PAGE_MS    1000         page dwell time in PLAY, ms
//  BLINK_MS   250          blink half-period in WIN, ms
//  WIN_SCORE  3            winning score, 1..3 (fits the 2-bit score)
// PORTS
//  clk        in   1  system clock (100 MHz), single clock domain
//  rst        in   1  synchronous reset, active-high
//  point_p1   in   1  1-cycle pulse: player 1 scored
//  point_p2   in   1  1-cycle pulse: player 2 scored
//  new_game   in   1  1-cycle pulse: clear scores, restart
//  digit3     out  3  code, leftmost digit (registered)
//  digit2     out  3  code
//  digit1     out  3  code
//  digit0     out  3  code, rightmost digit
//  blank      out  4  per-digit blank, 1 = off (bit n = digitn)
//  score_p1   out  2  player 1 score
//  score_p2   out  2  player 2 score
//  game_over  out  1  high while in WIN
//  winner     out  2  01 = P1, 10 = P2, 11 = draw, 00 = none
// BEHAVIOUR
//  Codes: 000..011 = digits 0..3; 100 = 'P'; 101 = '-'; 111 = blank glyph.
//  Reset: scores = 0, state PLAY, page P1, timers = 0, blank = 0000,
//   game_over = 0, winner = 00, digits = {100,001,101,000} ("P1-0").
//  ms tick: prescaler counts 0..CLK_HZ/1000-1 and pulses once per wrap.
//   Page and blink timers advance only on the tick.
//  FSM states: PLAY_P1, PLAY_P2, WIN.
//   PLAY_Pn: show "Pn-<score_pn>". After PAGE_MS ticks, go to the other page
//    and clear the page timer.
//   point_pn in PLAY: score_pn += 1 and jump to page Pn (same page re-entered),
//    page timer cleared. Both pulses in one cycle: both scores increment, page = P1.
//   Post-increment score == WIN_SCORE: go to WIN; winner = 01/10.
//    Both players reach WIN_SCORE in the same cycle: winner = 11.
//   WIN: point pulses are ignored and scores freeze (never exceed WIN_SCORE).
//    Shows the winner page; for a draw, shows "----" (101 x4).
//    blank toggles 0000 <-> 1111 every BLINK_MS ticks, starting with 0000.
//  new_game (any state) -> PLAY_P1, scores 0, timers and prescaler cleared,
//   winner 00, blank 0000. new_game has priority over same-cycle point pulses.
//  Latency: all outputs are registered, one cycle after the causing input edge.
//  rst mid-operation behaves the same as new_game, with the reset values above.
// STRUCTURE
//  score_disp_pkg: code constants (CODE_P, CODE_DASH, CODE_BLANK), FSM state
//   encodings, winner encodings.
//  Sub-module ms_tick_gen (CLK_HZ): clk, rst, clr -> tick. clr is driven by new_game.
//  Top: FSM, score registers, page/blink timers, digit encode register.
// TESTING  (bench params: CLK_HZ=1000 so tick every cycle, PAGE_MS=4, BLINK_MS=2)
//  After rst, idle 4 cycles -> digits "P1-0" to "P2-0" exactly at the 4th tick.
//   Then back to "P1-0" 4 ticks later.
//  point_p2 during "P1-0" page -> next cycle "P2-1", score_p2=1, page timer restarts
//   (dwell of 4 ticks from the jump).
//  Three point_p1 pulses -> "P1-3", game_over=1, winner=01.
//   blank: 0000 for 2 ticks, then 1111, then 0000.
//   A further point_p2 leaves score_p2 unchanged.
//  Scores 2-2, point_p1 and point_p2 on the same cycle -> winner=11,
//   digits "----", game_over=1.
//  new_game on the same cycle as point_p1 while in WIN -> "P1-0", scores 0,
//   game_over=0, winner=00, blank=0000.
//  rst asserted mid-page with score 1-2 -> next cycle all reset values,
//   prescaler restarts from 0.

Source files
------------

// File: rtl/score_disp_pkg.sv
// Shared glyph codes, FSM state encodings and winner encodings for the score display controller.
package score_disp_pkg;

    localparam logic [2:0] CODE_P     = 3'b100;
    localparam logic [2:0] CODE_DASH  = 3'b101;
    localparam logic [2:0] CODE_BLANK = 3'b111;

    localparam logic [1:0] ST_PLAY_P1 = 2'd0;
    localparam logic [1:0] ST_PLAY_P2 = 2'd1;
    localparam logic [1:0] ST_WIN     = 2'd2;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;
    localparam logic [1:0] WINNER_DRAW = 2'b11;

    // "Pn-s" packed as {digit3, digit2, digit1, digit0}; page is 1 or 2.
    function automatic logic [11:0] page_code(input logic [1:0] page, input logic [1:0] score);
        return {CODE_P, {1'b0, page}, CODE_DASH, {1'b0, score}};
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond strobe: counts 0..CLK_HZ/1000-1 and pulses tick on the wrap cycle.
// clr restarts the count from 0 on the next cycle.
module ms_tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Score keeping, page rotation and win blinking for the 4-digit 7-seg display.
// All outputs registered; they reflect an input pulse one cycle after it is sampled.
module score_display_ctrl
    import score_disp_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int PAGE_MS   = 1000,
    parameter int BLINK_MS  = 250,
    parameter int WIN_SCORE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       point_p1,
    input  logic       point_p2,
    input  logic       new_game,
    output logic [2:0] digit3,
    output logic [2:0] digit2,
    output logic [2:0] digit1,
    output logic [2:0] digit0,
    output logic [3:0] blank,
    output logic [1:0] score_p1,
    output logic [1:0] score_p2,
    output logic       game_over,
    output logic [1:0] winner
);
    localparam int PW = (PAGE_MS > 1) ? $clog2(PAGE_MS) : 1;
    localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
    localparam logic [PW-1:0] PAGE_LAST  = PW'(PAGE_MS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);
    localparam logic [1:0]    WIN_S      = 2'(WIN_SCORE);

    logic          tick;
    logic [1:0]    state_q, state_d;
    logic [1:0]    s1_q, s1_d, s2_q, s2_d;
    logic [PW-1:0] page_tmr_q, page_tmr_d;
    logic [BW-1:0] blink_tmr_q, blink_tmr_d;
    logic [3:0]    blank_q, blank_d;
    logic [1:0]    winner_q, winner_d;
    logic [11:0]   digits_q, digits_d;
    logic          win1, win2;

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (new_game),
        .tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        page_tmr_d  = page_tmr_q;
        blink_tmr_d = blink_tmr_q;
        blank_d     = blank_q;
        winner_d    = winner_q;
        win1        = 1'b0;
        win2        = 1'b0;

        if (new_game) begin
            state_d     = ST_PLAY_P1;
            s1_d        = '0;
            s2_d        = '0;
            page_tmr_d  = '0;
            blink_tmr_d = '0;
            blank_d     = '0;
            winner_d    = WINNER_NONE;
        end else if (state_q == ST_WIN) begin
            if (tick) begin
                if (blink_tmr_q == BLINK_LAST) begin
                    blink_tmr_d = '0;
                    blank_d     = ~blank_q;
                end else begin
                    blink_tmr_d = blink_tmr_q + BW'(1);
                end
            end
        end else if (point_p1 || point_p2) begin
            s1_d       = s1_q + {1'b0, point_p1};
            s2_d       = s2_q + {1'b0, point_p2};
            page_tmr_d = '0;
            state_d    = point_p1 ? ST_PLAY_P1 : ST_PLAY_P2;
            win1       = (s1_d == WIN_S);
            win2       = (s2_d == WIN_S);
            if (win1 || win2) begin
                state_d     = ST_WIN;
                winner_d    = {win2, win1};
                blink_tmr_d = '0;
                blank_d     = '0;
            end
        end else if (tick) begin
            if (page_tmr_q == PAGE_LAST) begin
                page_tmr_d = '0;
                state_d    = (state_q == ST_PLAY_P1) ? ST_PLAY_P2 : ST_PLAY_P1;
            end else begin
                page_tmr_d = page_tmr_q + PW'(1);
            end
        end

        case (state_d)
            ST_PLAY_P1: digits_d = page_code(2'd1, s1_d);
            ST_PLAY_P2: digits_d = page_code(2'd2, s2_d);
            default: begin
                if (winner_d == WINNER_DRAW) begin
                    digits_d = {4{CODE_DASH}};
                end else if (winner_d == WINNER_P1) begin
                    digits_d = page_code(2'd1, s1_d);
                end else begin
                    digits_d = page_code(2'd2, s2_d);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PLAY_P1;
            s1_q        <= '0;
            s2_q        <= '0;
            page_tmr_q  <= '0;
            blink_tmr_q <= '0;
            blank_q     <= '0;
            winner_q    <= WINNER_NONE;
            digits_q    <= page_code(2'd1, 2'd0);
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            page_tmr_q  <= page_tmr_d;
            blink_tmr_q <= blink_tmr_d;
            blank_q     <= blank_d;
            winner_q    <= winner_d;
            digits_q    <= digits_d;
        end
    end

    assign digit3    = digits_q[11:9];
    assign digit2    = digits_q[8:6];
    assign digit1    = digits_q[5:3];
    assign digit0    = digits_q[2:0];
    assign blank     = blank_q;
    assign score_p1  = s1_q;
    assign score_p2  = s2_q;
    assign game_over = (state_q == ST_WIN);
    assign winner    = winner_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed scenarios plus random pulses against an arithmetic model of the game rules.
module tb_score_display_ctrl;
    localparam int PAGE_MS   = 4;
    localparam int BLINK_MS  = 2;
    localparam int WIN_SCORE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       point_p1 = 1'b0;
    logic       point_p2 = 1'b0;
    logic       new_game = 1'b0;
    logic [2:0] digit3, digit2, digit1, digit0;
    logic [3:0] blank;
    logic [1:0] score_p1, score_p2, winner;
    logic       game_over;

    int n_checks = 0;
    int n_errors = 0;

    // model state: plain integers, timers count elapsed ticks
    int m_s1 = 0, m_s2 = 0, m_page = 1, m_page_ticks = 0, m_win_ticks = 0;
    bit m_win = 0;
    int m_winner = 0;

    score_display_ctrl #(
        .CLK_HZ(1000), .PAGE_MS(PAGE_MS), .BLINK_MS(BLINK_MS), .WIN_SCORE(WIN_SCORE)
    ) dut (
        .clk(clk), .rst(rst), .point_p1(point_p1), .point_p2(point_p2), .new_game(new_game),
        .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
        .blank(blank), .score_p1(score_p1), .score_p2(score_p2),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] dig_glyph(input int d3, input int d2, input int d1, input int d0);
        return {d3[2:0], d2[2:0], d1[2:0], d0[2:0]};
    endfunction

    function automatic logic [11:0] model_digits();
        int p;
        if (m_win && m_winner == 3) return dig_glyph(5, 5, 5, 5);
        p = m_win ? ((m_winner == 1) ? 1 : 2) : m_page;
        return dig_glyph(4, p, 5, (p == 1) ? m_s1 : m_s2);
    endfunction

    task automatic model_step(input bit r, input bit ng, input bit a, input bit b);
        if (r || ng) begin
            m_s1 = 0; m_s2 = 0; m_page = 1; m_page_ticks = 0;
            m_win = 0; m_winner = 0; m_win_ticks = 0;
        end else if (m_win) begin
            m_win_ticks++;
        end else if (a || b) begin
            m_s1 += int'(a);
            m_s2 += int'(b);
            m_page = a ? 1 : 2;
            m_page_ticks = 0;
            if (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE) begin
                m_win = 1;
                m_win_ticks = 0;
                m_winner = ((m_s2 == WIN_SCORE) ? 2 : 0) + ((m_s1 == WIN_SCORE) ? 1 : 0);
            end
        end else begin
            m_page_ticks++;
            if (m_page_ticks == PAGE_MS) begin
                m_page = 3 - m_page;
                m_page_ticks = 0;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        logic [3:0] exp_blank;
        exp_blank = (m_win && ((m_win_ticks / BLINK_MS) % 2 == 1)) ? 4'hF : 4'h0;
        check({tag, ".digits"}, {digit3, digit2, digit1, digit0}, model_digits());
        check({tag, ".blank"}, blank, exp_blank);
        check({tag, ".score_p1"}, score_p1, m_s1);
        check({tag, ".score_p2"}, score_p2, m_s2);
        check({tag, ".game_over"}, game_over, m_win);
        check({tag, ".winner"}, winner, m_winner);
    endtask

    task automatic step(input string tag, input bit r, input bit ng, input bit a, input bit b);
        rst = r; new_game = ng; point_p1 = a; point_p2 = b;
        @(posedge clk);
        model_step(r, ng, a, b);
        #1;
        rst = 0; new_game = 0; point_p1 = 0; point_p2 = 0;
        compare_model(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0);
    endtask

    initial begin
        step("reset", 1, 0, 0, 0);
        step("reset", 1, 0, 0, 0);
        check("reset.digits", {digit3, digit2, digit1, digit0}, 12'b100_001_101_000);
        check("reset.blank", blank, 4'b0000);

        idle("page", 3);
        check("page.still_p1", {digit3, digit2, digit1, digit0}, 12'b100_001_101_000);
        idle("page", 1);
        check("page.p2_at_4th", {digit3, digit2, digit1, digit0}, 12'b100_010_101_000);
        idle("page", 4);
        check("page.back_p1", {digit3, digit2, digit1, digit0}, 12'b100_001_101_000);

        step("p2pt", 0, 0, 0, 1);
        check("p2pt.digits", {digit3, digit2, digit1, digit0}, 12'b100_010_101_001);
        check("p2pt.score", score_p2, 2'd1);
        idle("p2dwell", 3);
        check("p2dwell.hold", {digit3, digit2, digit1, digit0}, 12'b100_010_101_001);
        idle("p2dwell", 1);
        check("p2dwell.swap", {digit3, digit2, digit1, digit0}, 12'b100_001_101_000);

        for (int i = 0; i < 3; i++) step("p1win", 0, 0, 1, 0);
        check("p1win.digits", {digit3, digit2, digit1, digit0}, 12'b100_001_101_011);
        check("p1win.game_over", game_over, 1'b1);
        check("p1win.winner", winner, 2'b01);
        check("p1win.blank0", blank, 4'b0000);
        idle("blink", 1);
        check("blink.still_on", blank, 4'b0000);
        idle("blink", 1);
        check("blink.off", blank, 4'b1111);
        idle("blink", 2);
        check("blink.on_again", blank, 4'b0000);
        step("winfreeze", 0, 0, 0, 1);
        check("winfreeze.score_p2", score_p2, 2'd1);

        step("ng_prio", 0, 1, 1, 0);
        check("ng_prio.digits", {digit3, digit2, digit1, digit0}, 12'b100_001_101_000);
        check("ng_prio.game_over", game_over, 1'b0);
        check("ng_prio.winner", winner, 2'b00);

        step("draw", 0, 0, 1, 0);
        step("draw", 0, 0, 0, 1);
        step("draw", 0, 0, 1, 0);
        step("draw", 0, 0, 0, 1);
        step("draw", 0, 0, 1, 1);
        check("draw.winner", winner, 2'b11);
        check("draw.digits", {digit3, digit2, digit1, digit0}, 12'b101_101_101_101);
        check("draw.game_over", game_over, 1'b1);
        idle("draw_blink", 3);

        step("midrst", 0, 1, 0, 0);
        step("midrst", 0, 0, 1, 0);
        step("midrst", 0, 0, 0, 1);
        step("midrst", 0, 0, 0, 1);
        idle("midrst", 1);
        step("midrst", 1, 0, 0, 0);
        check("midrst.digits", {digit3, digit2, digit1, digit0}, 12'b100_001_101_000);
        check("midrst.scores", {score_p1, score_p2}, 4'b0000);
        idle("midrst_page", 4);
        check("midrst.page_restart", {digit3, digit2, digit1, digit0}, 12'b100_010_101_000);

        for (int i = 0; i < 600; i++) begin
            bit r, ng, a, b;
            r  = ($urandom_range(0, 99) < 1);
            ng = ($urandom_range(0, 99) < 3);
            a  = ($urandom_range(0, 99) < 12);
            b  = ($urandom_range(0, 99) < 12);
            step("rand", r, ng, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
